// File: rtl/main_ram_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// main_ram_ctrl_if : host-side request/response bus of main_ram_ctrl
// Rev 1.0
// ------------------------------------------------------------------
interface main_ram_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             we;
  logic [19:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input  busy, done, rdata);
  modport slave  (input  req, we, addr, wdata, output busy, done, rdata);
endinterface
`default_nettype wire

// File: rtl/main_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// main_ram_ctrl : single-access asynchronous SRAM controller
// Rev 1.0
// ------------------------------------------------------------------
module main_ram_ctrl #(
  parameter int WIDTH    = 8,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  wire               clk,
  input  wire               _reset,
  main_ram_ctrl_if.slave    bus,
  output logic              _cs,
  output logic              _oe,
  output logic              _w,
  output logic [19:0]       ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  wire  [WIDTH-1:0]  ram_rdata
);

  localparam int WP_EFF  = (WR_PULSE < 1) ? 1 : WR_PULSE;
  localparam int CNT_MAX = ((RD_WAIT + 1) > WP_EFF) ? (RD_WAIT + 1) : WP_EFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WP_EFF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_cs_n;
  logic             w_oe_n;
  logic             w_w_n;
  logic             w_busy;
  logic             w_done;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_rdata;

  // Counter holds "remaining cycles minus one" of the current timed state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          if (bus.we) begin
            w_state_nxt = WR_SETUP;
          end else begin
            w_state_nxt = RD_ACCESS;
            w_cnt_nxt   = RD_LOAD;
          end
        end
      end
      RD_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      WR_SETUP: begin
        w_state_nxt = WR_STROBE;
        w_cnt_nxt   = WR_LOAD;
      end
      WR_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      WR_HOLD: w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops show the new state's levels.
    w_cs_n = !((w_state_nxt == RD_ACCESS) || (w_state_nxt == WR_SETUP) ||
               (w_state_nxt == WR_STROBE) || (w_state_nxt == WR_HOLD));
    w_oe_n = (w_state_nxt != RD_ACCESS);
    w_w_n  = (w_state_nxt != WR_STROBE);
    w_busy = (w_state_nxt != IDLE);
    w_done = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      _cs       <= 1'b1;
      _oe       <= 1'b1;
      _w        <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      _cs     <= w_cs_n;
      _oe     <= w_oe_n;
      _w      <= w_w_n;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_accept) begin
        ram_addr  <= bus.addr;
        ram_wdata <= bus.wdata;
      end
      if (w_capture) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_main_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_main_ram_ctrl : two instances (RD_WAIT=2/WR_PULSE=2 and 0/0) on shared stimulus
// Rev 1.0
// ------------------------------------------------------------------
module tb_main_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] addr = '0;
  logic [7:0]  wdata = '0;

  always #5 clk = ~clk;

  main_ram_ctrl_if #(.WIDTH(8)) bus_a ();
  main_ram_ctrl_if #(.WIDTH(8)) bus_b ();

  assign bus_a.req = req;  assign bus_a.we = we;  assign bus_a.addr = addr;  assign bus_a.wdata = wdata;
  assign bus_b.req = req;  assign bus_b.we = we;  assign bus_b.addr = addr;  assign bus_b.wdata = wdata;

  logic        cs_a, oe_a, w_a, cs_b, oe_b, w_b;
  logic [19:0] ram_addr_a, ram_addr_b;
  logic [7:0]  ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;

  main_ram_ctrl #(.WIDTH(8), .RD_WAIT(2), .WR_PULSE(2)) u_a (
    .clk(clk), ._reset(rst_n), .bus(bus_a), ._cs(cs_a), ._oe(oe_a), ._w(w_a),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a));

  main_ram_ctrl #(.WIDTH(8), .RD_WAIT(0), .WR_PULSE(0)) u_b (
    .clk(clk), ._reset(rst_n), .bus(bus_b), ._cs(cs_b), ._oe(oe_b), ._w(w_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b));

  // SRAM models: write on any clock where _cs and _w are low, asynchronous read.
  bit [7:0]    mem_a [0:1048575];
  bit [7:0]    mem_b [0:1048575];
  bit          pre_go = 1'b0;
  logic [19:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_go) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end
    if (!cs_a && !w_a) mem_a[ram_addr_a] <= ram_wdata_a;
    if (!cs_b && !w_b) mem_b[ram_addr_b] <= ram_wdata_b;
  end
  assign ram_rdata_a = mem_a[ram_addr_a];
  assign ram_rdata_b = mem_b[ram_addr_b];

  logic [1:0]  cs_n, oe_n, w_n, bsy, dn;
  logic [19:0] raddr [2];
  logic [7:0]  rwd [2];
  logic [7:0]  rdat [2];
  assign cs_n = {cs_b, cs_a};
  assign oe_n = {oe_b, oe_a};
  assign w_n  = {w_b, w_a};
  assign bsy  = {bus_b.busy, bus_a.busy};
  assign dn   = {bus_b.done, bus_a.done};
  assign raddr[0] = ram_addr_a;   assign raddr[1] = ram_addr_b;
  assign rwd[0]   = ram_wdata_a;  assign rwd[1]   = ram_wdata_b;
  assign rdat[0]  = bus_a.rdata;  assign rdat[1]  = bus_b.rdata;

  // Reference model: memory contents and expected rdata per instance.
  bit [7:0] model_mem [0:1048575];
  logic [7:0] exp_rd [2];
  bit         rd_known [2];
  int         rw_of [2] = '{2, 0};
  int         wp_of [2] = '{2, 1};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request starting in the current low clock phase and observes a fixed window.
  task automatic txn(input logic t_we, input logic [19:0] t_addr, input logic [7:0] t_wd, input string tag);
    int lat[2], ncs[2], noe[2], nw[2], wstart[2], ndone[2], bad[2], badaddr[2];
    logic busy1[2];
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; ncs[i] = 0; noe[i] = 0; nw[i] = 0; wstart[i] = 0;
      ndone[i] = 0; bad[i] = 0; badaddr[i] = 0; busy1[i] = 1'b0;
    end
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (k == 1) busy1[i] = bsy[i];
        if (!cs_n[i]) ncs[i]++;
        if (!oe_n[i]) noe[i]++;
        if (!w_n[i]) begin nw[i]++; if (wstart[i] == 0) wstart[i] = k; end
        if (dn[i]) begin ndone[i]++; if (lat[i] == 0) lat[i] = k; end
        if ((!oe_n[i] && !w_n[i]) || (t_we && !oe_n[i]) || (!t_we && !w_n[i])) bad[i]++;
        if (bsy[i] && (raddr[i] !== t_addr || (t_we && rwd[i] !== t_wd))) badaddr[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d] busy_first", tag, i), busy1[i], 1);
      chk($sformatf("%s[%0d] done_latency", tag, i), lat[i], t_we ? wp_of[i] + 3 : rw_of[i] + 2);
      chk($sformatf("%s[%0d] cs_cycles", tag, i), ncs[i], t_we ? wp_of[i] + 2 : rw_of[i] + 1);
      chk($sformatf("%s[%0d] oe_cycles", tag, i), noe[i], t_we ? 0 : rw_of[i] + 1);
      chk($sformatf("%s[%0d] w_cycles", tag, i), nw[i], t_we ? wp_of[i] : 0);
      chk($sformatf("%s[%0d] w_start", tag, i), wstart[i], t_we ? 2 : 0);
      chk($sformatf("%s[%0d] done_pulses", tag, i), ndone[i], 1);
      chk($sformatf("%s[%0d] strobe_conflict", tag, i), bad[i], 0);
      chk($sformatf("%s[%0d] addr_data_unstable", tag, i), badaddr[i], 0);
      chk($sformatf("%s[%0d] busy_end", tag, i), bsy[i], 0);
      chk($sformatf("%s[%0d] addr_held_idle", tag, i), raddr[i], t_addr);
      if (!t_we) begin
        exp_rd[i] = model_mem[t_addr];
        rd_known[i] = 1'b1;
      end
      if (rd_known[i]) chk($sformatf("%s[%0d] rdata", tag, i), rdat[i], exp_rd[i]);
    end
    if (t_we) model_mem[t_addr] = t_wd;
  endtask

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int oe2[2], ndn[2], noe[2];
    bit seen[2];
    logic [19:0] ra;
    logic rwe;

    tbl[0] = '{1'b0, 20'h00010, 8'h00, 8'hA5};
    tbl[1] = '{1'b1, 20'h00020, 8'h3C, 8'hA5};
    tbl[2] = '{1'b0, 20'h00020, 8'h00, 8'h3C};
    tbl[3] = '{1'b1, 20'hFFFFF, 8'hFF, 8'h3C};
    tbl[4] = '{1'b0, 20'hFFFFF, 8'h00, 8'hFF};
    tbl[5] = '{1'b1, 20'h00000, 8'h5A, 8'hFF};
    tbl[6] = '{1'b0, 20'h00000, 8'h00, 8'h5A};
    tbl[7] = '{1'b0, 20'h00010, 8'h00, 8'hA5};

    for (int i = 0; i < 2; i++) begin exp_rd[i] = 8'h00; rd_known[i] = 1'b1; end

    // Reset state, with a preload of the SRAM models while reset is held.
    pre_addr = 20'h00010; pre_data = 8'hA5; pre_go = 1'b1;
    model_mem[20'h00010] = 8'hA5;
    repeat (2) @(negedge clk);
    pre_go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst[%0d] cs", i), cs_n[i], 1);
      chk($sformatf("rst[%0d] oe", i), oe_n[i], 1);
      chk($sformatf("rst[%0d] w", i), w_n[i], 1);
      chk($sformatf("rst[%0d] busy", i), bsy[i], 0);
      chk($sformatf("rst[%0d] done", i), dn[i], 0);
      chk($sformatf("rst[%0d] rdata", i), rdat[i], 0);
      chk($sformatf("rst[%0d] ram_addr", i), raddr[i], 0);
      chk($sformatf("rst[%0d] ram_wdata", i), rwd[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int v = 0; v < 8; v++) begin
      txn(tbl[v].we, tbl[v].addr, tbl[v].wdata, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d table_rdata_a", v), rdat[0], tbl[v].exp_rdata);
    end

    // Held request: second read starts right after the one IDLE cycle following DONE.
    req = 1'b1; we = 1'b0; addr = 20'h00010; wdata = 8'h00;
    for (int i = 0; i < 2; i++) begin oe2[i] = 0; ndn[i] = 0; seen[i] = 1'b0; end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) begin ndn[i]++; seen[i] = 1'b1; end
        else if (seen[i] && !oe_n[i] && oe2[i] == 0) oe2[i] = k;
      end
      if (k == 6) req = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("held[%0d] second_start", i), oe2[i], rw_of[i] + 4);
      chk($sformatf("held[%0d] done_pulses", i), ndn[i], 2);
      chk($sformatf("held[%0d] busy_end", i), bsy[i], 0);
      chk($sformatf("held[%0d] rdata", i), rdat[i], model_mem[20'h00010]);
      exp_rd[i] = model_mem[20'h00010];
    end

    // Request pulses while busy with a write must not start a read.
    req = 1'b1; we = 1'b1; addr = 20'h00040; wdata = 8'h77;
    for (int i = 0; i < 2; i++) begin ndn[i] = 0; noe[i] = 0; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) ndn[i]++;
        if (!oe_n[i]) noe[i]++;
      end
      we = 1'b0;
      req = (k == 1 || k == 3);
    end
    model_mem[20'h00040] = 8'h77;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pulse[%0d] done_pulses", i), ndn[i], 1);
      chk($sformatf("pulse[%0d] oe_cycles", i), noe[i], 0);
      chk($sformatf("pulse[%0d] rdata", i), rdat[i], exp_rd[i]);
    end
    txn(1'b0, 20'h00040, 8'h00, "pulse_readback");

    // Reset in the middle of a read acts without a clock edge.
    req = 1'b1; we = 1'b0; addr = 20'h00010;
    @(negedge clk);
    req = 1'b0;
    chk("midrd oe_low_before", oe_n[0], 0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrd[%0d] cs", i), cs_n[i], 1);
      chk($sformatf("midrd[%0d] oe", i), oe_n[i], 1);
      chk($sformatf("midrd[%0d] busy", i), bsy[i], 0);
      chk($sformatf("midrd[%0d] rdata", i), rdat[i], 0);
      ndn[i] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (dn[i]) ndn[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrd[%0d] no_done", i), ndn[i], 0);
      exp_rd[i] = 8'h00;
      rd_known[i] = 1'b1;
    end
    rst_n = 1'b1;
    txn(1'b0, 20'h00010, 8'h00, "post_reset");

    // Randomized traffic against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 20'hFFFFF;
        1: ra = 20'h00000;
        default: ra = 20'($urandom_range(0, 15));
      endcase
      rwe = 1'($urandom_range(0, 1));
      txn(rwe, ra, 8'($urandom), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
